matrix_math_3x3: RTL and testbench

//  Command-driven 3x3 matrix multiplier, C = A x B, with 8-bit elements and 18-bit results.
//  ui_in carries the data byte and uio_in carries the command byte.

---
 rtl/matrix_math_3x3.sv | 104 ++++++++++
 tb/tb_matrix_math_3x3.sv | 299 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/matrix_math_3x3.sv
// Command-driven 3x3 matrix multiplier C = A x B behind 8-bit data/command pads.
// Optional macro MATRIXMATH_SIGNED_EN selects two's-complement elements and the signed overflow rule.
module matrix_math_3x3 #(
  parameter int DW = 8,
  parameter int CW = 18
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic [DW-1:0] ui_in,
  input  logic [7:0]    uio_in,
  output logic [7:0]    uo_out
);

  logic [DW-1:0] a_reg [0:8];
  logic [DW-1:0] b_reg [0:8];
  logic [CW-1:0] c_val [0:8];
  logic [8:0]    ovf_vec;
  logic          ovf;
  logic [7:0]    uo_reg;

  logic [3:0] cmd_hi;
  logic [3:0] cmd_lo;
  logic [3:0] row_sel;
  logic [3:0] elem_idx;
  logic       lo_ok;
  logic       load_a;
  logic       load_b;
  logic       rd_lo;
  logic       rd_hi;
  logic       rd_ovf;
  logic       clr;

`ifdef MATRIXMATH_SIGNED_EN
  function automatic logic signed [CW-1:0] ext(input logic [DW-1:0] v);
    return CW'($signed(v));
  endfunction
`else
  function automatic logic signed [CW-1:0] ext(input logic [DW-1:0] v);
    return CW'(v);
  endfunction
`endif

  // One dot product per C element; the 18-bit width holds three full products without loss.
  genvar gi;
  generate
    for (gi = 0; gi < 9; gi++) begin : g_elem
      localparam int ROW = gi / 3;
      localparam int COL = gi % 3;
      logic signed [CW-1:0] sum;

      assign sum = ext(a_reg[3*ROW])   * ext(b_reg[COL])
                 + ext(a_reg[3*ROW+1]) * ext(b_reg[3+COL])
                 + ext(a_reg[3*ROW+2]) * ext(b_reg[6+COL]);
      assign c_val[gi] = sum;
`ifdef MATRIXMATH_SIGNED_EN
      assign ovf_vec[gi] = !((sum[17:15] == 3'b000) || (sum[17:15] == 3'b111));
`else
      assign ovf_vec[gi] = |sum[17:16];
`endif
    end
  endgenerate

  assign ovf = |ovf_vec;

  always_comb begin
    cmd_hi   = uio_in[7:4];
    cmd_lo   = uio_in[3:0];
    lo_ok    = (cmd_lo >= 4'd1) && (cmd_lo <= 4'd3);
    load_a   = (cmd_hi >= 4'd1) && (cmd_hi <= 4'd3) && lo_ok;
    load_b   = (cmd_hi >= 4'd4) && (cmd_hi <= 4'd6) && lo_ok;
    row_sel  = load_b ? (cmd_hi - 4'd4) : (cmd_hi - 4'd1);
    elem_idx = row_sel * 4'd3 + cmd_lo - 4'd1;
    rd_lo    = (cmd_hi == 4'hD) && (cmd_lo <= 4'd8);
    rd_hi    = (cmd_hi == 4'hE) && (cmd_lo <= 4'd8);
    rd_ovf   = (uio_in == 8'hEE);
    clr      = (uio_in == 8'hAA);
  end

  always_ff @(posedge clk) begin
    if (rst_n) begin
      for (int i = 0; i < 9; i++) begin
        a_reg[i] <= '0;
        b_reg[i] <= '0;
      end
      uo_reg <= '0;
    end else begin
      if (load_a) a_reg[elem_idx] <= ui_in;
      if (load_b) b_reg[elem_idx] <= ui_in;
      if (clr) begin
        for (int i = 0; i < 9; i++) begin
          a_reg[i] <= '0;
          b_reg[i] <= '0;
        end
        uo_reg <= '0;
      end
      if (rd_lo)  uo_reg <= c_val[cmd_lo][7:0];
      if (rd_hi)  uo_reg <= c_val[cmd_lo][15:8];
      if (rd_ovf) uo_reg <= {7'b0, ovf};
    end
  end

  assign uo_out = uo_reg;

endmodule

// File: tb/tb_matrix_math_3x3.sv
// Self-checking bench for matrix_math_3x3: directed cases plus random commands against a matrix model.
module tb_matrix_math_3x3;

  logic       clk = 1'b0;
  logic       rst_n = 1'b1;
  logic [7:0] ui_in = 8'h00;
  logic [7:0] uio_in = 8'hBB;
  logic [7:0] uo_out;

  int         n_vec = 0;
  int         n_err = 0;
  int         ma [9];
  int         mb [9];
  logic [7:0] exp_uo = 8'h00;

  matrix_math_3x3 dut (
    .clk   (clk),
    .rst_n (rst_n),
    .ui_in (ui_in),
    .uio_in(uio_in),
    .uo_out(uo_out)
  );

  always #5 clk = ~clk;

  function automatic int elem_val(int v);
`ifdef MATRIXMATH_SIGNED_EN
    return (v > 127) ? v - 256 : v;
`else
    return v;
`endif
  endfunction

  function automatic int c_full(int k);
    int i = k / 3;
    int j = k % 3;
    int s = 0;
    for (int n = 0; n < 3; n++) s += elem_val(ma[3*i+n]) * elem_val(mb[3*n+j]);
    return s;
  endfunction

  function automatic int any_ovf();
    int s;
    for (int k = 0; k < 9; k++) begin
      s = c_full(k);
`ifdef MATRIXMATH_SIGNED_EN
      if (s > 32767 || s < -32768) return 1;
`else
      if (s > 65535) return 1;
`endif
    end
    return 0;
  endfunction

  function automatic void model_clear();
    for (int k = 0; k < 9; k++) begin
      ma[k] = 0;
      mb[k] = 0;
    end
  endfunction

  // Drive one command for one clock, then advance the model to match the sampled edge.
  task automatic apply(input logic [7:0] cmd, input logic [7:0] data);
    int hi;
    int lo;
    uio_in = cmd;
    ui_in  = data;
    @(posedge clk);
    #1;
    hi = int'(cmd) / 16;
    lo = int'(cmd) % 16;
    if (rst_n) begin
      model_clear();
      exp_uo = 8'h00;
    end else if (hi >= 1 && hi <= 3 && lo >= 1 && lo <= 3) begin
      ma[3*(hi-1) + lo-1] = int'(data);
    end else if (hi >= 4 && hi <= 6 && lo >= 1 && lo <= 3) begin
      mb[3*(hi-4) + lo-1] = int'(data);
    end else if (hi == 13 && lo <= 8) begin
      exp_uo = 8'(c_full(lo) & 255);
    end else if (hi == 14 && lo <= 8) begin
      exp_uo = 8'((c_full(lo) >> 8) & 255);
    end else if (cmd == 8'hEE) begin
      exp_uo = 8'(any_ovf());
    end else if (cmd == 8'hAA) begin
      model_clear();
      exp_uo = 8'h00;
    end
    $display("rst=%0d cmd=%02h data=%02h uo_out=%02h expect=%02h", rst_n, cmd, data, uo_out, exp_uo);
  endtask

  task automatic test_reset();
    logic [7:0] rd [3] = '{8'hD0, 8'hE0, 8'hEE};
    rst_n = 1'b1;
    apply(8'h11, 8'h5A);
    apply(8'h41, 8'hA5);
    rst_n = 1'b0;
    n_vec++;
    if (uo_out !== 8'h00) begin
      n_err++;
      $display("FAIL reset_uo got=%02h want=00", uo_out);
    end
    for (int i = 0; i < 3; i++) begin
      apply(rd[i], 8'h00);
      n_vec++;
      if (uo_out !== 8'h00) begin
        n_err++;
        $display("FAIL reset_read cmd=%02h got=%02h want=00", rd[i], uo_out);
      end
    end
  endtask

  task automatic test_load_read();
    logic [7:0] rd [3] = '{8'hD0, 8'hE0, 8'hEE};
    logic [7:0] want [3] = '{8'h52, 8'h0C, 8'h00};
    apply(8'h11, 8'h53);
    apply(8'h41, 8'h26);
    for (int i = 0; i < 3; i++) begin
      apply(rd[i], 8'h00);
      n_vec++;
      if (uo_out !== want[i] || uo_out !== exp_uo) begin
        n_err++;
        $display("FAIL load_read cmd=%02h got=%02h want=%02h", rd[i], uo_out, want[i]);
      end
    end
  endtask

  task automatic test_all_ff();
    logic [7:0] rd [3] = '{8'hD0, 8'hE0, 8'hEE};
`ifdef MATRIXMATH_SIGNED_EN
    logic [7:0] want [3] = '{8'h03, 8'h00, 8'h00};
`else
    logic [7:0] want [3] = '{8'h03, 8'hFA, 8'h01};
`endif
    for (int r = 1; r <= 6; r++)
      for (int c = 1; c <= 3; c++) apply(8'(r*16 + c), 8'hFF);
    for (int i = 0; i < 3; i++) begin
      apply(rd[i], 8'h00);
      n_vec++;
      if (uo_out !== want[i] || uo_out !== exp_uo) begin
        n_err++;
        $display("FAIL all_ff cmd=%02h got=%02h want=%02h", rd[i], uo_out, want[i]);
      end
    end
    apply(8'hAA, 8'h00);
    n_vec++;
    if (uo_out !== 8'h00) begin
      n_err++;
      $display("FAIL clear_uo got=%02h want=00", uo_out);
    end
    apply(8'hD4, 8'h00);
    n_vec++;
    if (uo_out !== 8'h00) begin
      n_err++;
      $display("FAIL clear_d4 got=%02h want=00", uo_out);
    end
  endtask

  task automatic test_identity();
    logic [7:0] rd [3] = '{8'hD0, 8'hD5, 8'hE0};
`ifdef MATRIXMATH_SIGNED_EN
    logic [7:0] want [3] = '{8'hFE, 8'h54, 8'hFF};
`else
    logic [7:0] want [3] = '{8'hFE, 8'h54, 8'h00};
`endif
    apply(8'hAA, 8'h00);
    apply(8'h11, 8'h01);
    apply(8'h22, 8'h01);
    apply(8'h33, 8'h01);
    apply(8'h41, 8'hFE);
    apply(8'h53, 8'h54);
    for (int i = 0; i < 3; i++) begin
      apply(rd[i], 8'h00);
      n_vec++;
      if (uo_out !== want[i] || uo_out !== exp_uo) begin
        n_err++;
        $display("FAIL identity cmd=%02h got=%02h want=%02h", rd[i], uo_out, want[i]);
      end
    end
  endtask

  task automatic test_hold_invalid();
    logic [7:0] bad [6] = '{8'hBB, 8'h7F, 8'h10, 8'hD9, 8'h14, 8'hE9};
    logic [7:0] held;
    apply(8'hD0, 8'h00);
    held = exp_uo;
    for (int i = 0; i < 6; i++) begin
      apply(bad[i], 8'h99);
      n_vec++;
      if (uo_out !== held) begin
        n_err++;
        $display("FAIL hold cmd=%02h got=%02h want=%02h", bad[i], uo_out, held);
      end
    end
    for (int k = 0; k < 9; k++) begin
      apply(8'hD0 + 8'(k), 8'h00);
      n_vec++;
      if (uo_out !== exp_uo) begin
        n_err++;
        $display("FAIL hold_state k=%0d got=%02h want=%02h", k, uo_out, exp_uo);
      end
    end
  endtask

  task automatic test_signed_edge();
    logic [7:0] rd [3] = '{8'hD0, 8'hE0, 8'hEE};
`ifdef MATRIXMATH_SIGNED_EN
    logic [7:0] want [3] = '{8'hFE, 8'hFF, 8'h00};
`else
    logic [7:0] want [3] = '{8'hFE, 8'h01, 8'h00};
`endif
    apply(8'hAA, 8'h00);
    apply(8'h11, 8'hFF);
    apply(8'h41, 8'h02);
    for (int i = 0; i < 3; i++) begin
      apply(rd[i], 8'h00);
      n_vec++;
      if (uo_out !== want[i] || uo_out !== exp_uo) begin
        n_err++;
        $display("FAIL sign_edge cmd=%02h got=%02h want=%02h", rd[i], uo_out, want[i]);
      end
    end
  endtask

  task automatic test_back_to_back();
    logic [7:0] cmd;
    for (int t = 0; t < 40; t++) begin
      cmd = ($urandom_range(0, 1) == 0) ? 8'h10 : 8'h40;
      cmd = cmd + 8'($urandom_range(0, 2) * 16 + $urandom_range(1, 3));
      apply(cmd, 8'($urandom));
      cmd = (($urandom_range(0, 1) == 0) ? 8'hD0 : 8'hE0) + 8'($urandom_range(0, 8));
      apply(cmd, 8'h00);
      n_vec++;
      if (uo_out !== exp_uo) begin
        n_err++;
        $display("FAIL back_to_back cmd=%02h got=%02h want=%02h", cmd, uo_out, exp_uo);
      end
    end
  endtask

  task automatic test_random();
    logic [7:0] cmd;
    int op;
    for (int t = 0; t < 300; t++) begin
      op = int'($urandom_range(0, 20));
      if (op < 4)       cmd = 8'(16 * $urandom_range(1, 3) + $urandom_range(1, 3));
      else if (op < 8)  cmd = 8'(16 * $urandom_range(4, 6) + $urandom_range(1, 3));
      else if (op < 11) cmd = 8'hD0 + 8'($urandom_range(0, 8));
      else if (op < 14) cmd = 8'hE0 + 8'($urandom_range(0, 8));
      else if (op < 16) cmd = 8'hEE;
      else if (op < 17) cmd = 8'hAA;
      else              cmd = 8'($urandom);
      apply(cmd, 8'($urandom));
      n_vec++;
      if (uo_out !== exp_uo) begin
        n_err++;
        $display("FAIL random t=%0d cmd=%02h got=%02h want=%02h", t, cmd, uo_out, exp_uo);
      end
    end
  endtask

  task automatic test_reset_mid();
    apply(8'h11, 8'h77);
    apply(8'h41, 8'h33);
    apply(8'hD0, 8'h00);
    rst_n = 1'b1;
    apply(8'h12, 8'h55);
    rst_n = 1'b0;
    n_vec++;
    if (uo_out !== 8'h00) begin
      n_err++;
      $display("FAIL reset_mid_uo got=%02h want=00", uo_out);
    end
    for (int k = 0; k < 9; k++) begin
      apply(8'hD0 + 8'(k), 8'h00);
      n_vec++;
      if (uo_out !== 8'h00) begin
        n_err++;
        $display("FAIL reset_mid_read k=%0d got=%02h want=00", k, uo_out);
      end
    end
  endtask

  initial begin
    model_clear();
    test_reset();
    test_load_read();
    test_all_ff();
    test_identity();
    test_hold_invalid();
    test_signed_edge();
    test_back_to_back();
    test_random();
    test_reset_mid();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
